// File: rtl/boot_loader_stream.sv
// Boot loader: streams a program image into the instruction RAM, optionally re-reads it
// to confirm the running checksum, then hands the RAM port to the CPU and releases its reset.
module boot_loader_stream #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11,
  parameter int RD_LAT = 1,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              boot_mode,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  // Counters are one bit wider than the address so a full-depth image never wraps.
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  r_rcnt;
  logic [CNT_W-1:0]  r_ret;
  logic [DATA_W-1:0] r_checksum;
  logic [DATA_W-1:0] r_rsum;
  logic [RD_LAT-1:0] r_vpipe;

  logic [CNT_W-1:0]  w_len_clamped;
  logic              w_len_zero;
  logic              w_start_ok;
  logic              w_hs;
  logic              w_last_wr;
  logic              w_issue;
  logic              w_ret;
  logic              w_ver_end;

  assign w_len_clamped = (prog_len > DEPTH) ? DEPTH : prog_len;
  assign w_len_zero    = (w_len_clamped == '0);
  assign w_start_ok    = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_hs          = (r_state == S_LOAD) && s_valid;
  assign w_last_wr     = w_hs && (r_wcnt == r_len - ONE);
  assign w_issue       = (r_state == S_VERIFY) && (r_rcnt != r_len);
  assign w_ret         = (r_state == S_VERIFY) && r_vpipe[RD_LAT-1];
  assign w_ver_end     = (r_state == S_VERIFY) && (r_ret == r_len);

  // Status is decoded from registered state only, so it never glitches with stream inputs.
  assign boot_mode = (r_state != S_DONE);
  assign cpu_rst_n = (r_state == S_DONE);
  assign done      = (r_state == S_DONE);
  assign error     = (r_state == S_ERROR);
  assign checksum  = r_checksum;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next  = r_state;
    s_ready = 1'b0;
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = '0;
    ram_din = '0;
    unique case (r_state)
      S_IDLE, S_ERROR: begin
        if (w_start_ok) w_next = w_len_zero ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          ram_ce  = 1'b1;
          ram_wre = 1'b1;
          ram_ad  = r_wcnt[ADDR_W-1:0];
          ram_din = s_data;
        end
        if (w_last_wr) w_next = (VERIFY != 0) ? S_VERIFY : S_DONE;
      end
      S_VERIFY: begin
        ram_ce = 1'b1;
        ram_ad = r_rcnt[ADDR_W-1:0];
        if (w_ver_end) w_next = (r_rsum == r_checksum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        ram_ce = 1'b1;
        ram_ad = cpu_addr;
        if (w_start_ok) w_next = w_len_zero ? S_DONE : S_LOAD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_ret      <= '0;
      r_checksum <= '0;
      r_rsum     <= '0;
      r_vpipe    <= '0;
    end else begin
      r_state    <= w_next;
      // NOTE: non-blocking assignments keep every stage reading the pre-edge value of its neighbour.
      r_vpipe[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      if (w_start_ok) begin
        r_len      <= w_len_clamped;
        r_wcnt     <= '0;
        r_rcnt     <= '0;
        r_ret      <= '0;
        r_checksum <= '0;
        r_rsum     <= '0;
      end else begin
        if (w_hs) begin
          r_wcnt     <= r_wcnt + ONE;
          r_checksum <= r_checksum + s_data;
        end
        if (w_issue) r_rcnt <= r_rcnt + ONE;
        if (w_ret) begin
          r_rsum <= r_rsum + ram_dout;
          r_ret  <= r_ret + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_loader_stream.sv
// Self-checking bench for boot_loader_stream: behavioural RAM with read latency, write
// monitor, and an image/checksum reference model computed directly from the stream contents.
module tb_boot_loader_stream;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 11;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic              ram_ce;
  logic              ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;
  logic              boot_mode;
  logic              cpu_rst_n;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] checksum;

  int n_run  = 0;
  int n_fail = 0;

  boot_loader_stream #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .VERIFY(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .cpu_addr(cpu_addr),
    .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
    .ram_dout(ram_dout), .boot_mode(boot_mode), .cpu_rst_n(cpu_rst_n),
    .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Single-port RAM with RD_LAT cycles of read latency; corrupt_req flips bit 0 of word 5.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  logic              corrupt_req = 1'b0;

  always @(posedge clk) begin
    if (ram_ce && ram_wre) mem[ram_ad] <= ram_din;
    else if (corrupt_req)  mem[5] <= mem[5] ^ 16'h0001;
    if (ram_ce) rd_pipe[0] <= mem[ram_ad];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[RD_LAT-1];

  // Write monitor, sampled mid-cycle.
  int                cyc = 0;
  int                wl_cyc [$];
  logic [ADDR_W-1:0] wl_ad  [$];
  logic [DATA_W-1:0] wl_d   [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ram_ce === 1'b1 && ram_wre === 1'b1) begin
      wl_cyc.push_back(cyc);
      wl_ad.push_back(ram_ad);
      wl_d.push_back(ram_din);
    end
  end

  // Reference image and model.
  logic [DATA_W-1:0] img [DEPTH];

  function automatic logic [DATA_W-1:0] model_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += int'(img[i]);
    return s[DATA_W-1:0];
  endfunction

  function automatic int ram_bad_words(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) if (mem[i] !== img[i]) bad++;
    return bad;
  endfunction

  typedef struct {
    int   nwr;
    bit   addr_ok;
    bit   data_ok;
    bit   consec;
    bit   timed_out;
    int   vcycles;
    logic rstn_at_load;
  } res_t;

  // gap: 0 back-to-back, 1 every other cycle, 2 random. mid_start pulses a start mid-stream.
  task automatic run_load(input int req_len, input int gap, input bit corrupt,
                          input bit mid_start, output res_t r);
    int len = (req_len > DEPTH) ? DEPTH : req_len;
    int idx = 0;
    int budget = 4 * len + 50;
    bit ph = 1'b1;
    bit ms_done = 1'b0;
    wl_cyc.delete(); wl_ad.delete(); wl_d.delete();
    r.timed_out = 1'b0;
    start = 1'b1; prog_len = req_len[ADDR_W:0];
    @(posedge clk); #1;
    start = 1'b0;
    r.rstn_at_load = cpu_rst_n;
    while (idx < len) begin
      if (mid_start && !ms_done && idx == len / 2) begin
        start = 1'b1; prog_len = 5; ms_done = 1'b1;
      end else begin
        start = 1'b0;
      end
      case (gap)
        0:       s_valid = 1'b1;
        1:       begin s_valid = ph; ph = ~ph; end
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = s_valid ? img[idx] : DATA_W'($urandom);
      #1;
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      budget--;
      if (budget == 0) begin r.timed_out = 1'b1; break; end
    end
    start = 1'b0;
    s_valid = 1'b1; s_data = 16'hDEAD;
    r.vcycles = 0;
    while (!(done || error) && r.vcycles < len + 40) begin
      corrupt_req = corrupt && (r.vcycles == 0);
      @(posedge clk); #1;
      corrupt_req = 1'b0;
      r.vcycles++;
    end
    if (!(done || error)) r.timed_out = 1'b1;
    s_valid = 1'b0;
    r.nwr = wl_ad.size();
    r.addr_ok = (r.nwr == len);
    r.data_ok = (r.nwr == len);
    r.consec  = (r.nwr == len);
    for (int i = 0; i < r.nwr && i < len; i++) begin
      if (wl_ad[i] !== ADDR_W'(i)) r.addr_ok = 1'b0;
      if (wl_d[i] !== img[i]) r.data_ok = 1'b0;
      if (wl_cyc[i] != wl_cyc[0] + i) r.consec = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst = 1'b1; start = 1'b0; prog_len = '0; s_valid = 1'b0; s_data = '0; cpu_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    obs = {boot_mode, cpu_rst_n, s_ready, ram_ce, ram_wre, done, error};
    n_run++; if (obs !== 7'b1000000) begin n_fail++; $display("FAIL reset_status: got %b want 1000000", obs); end
    n_run++; if ({checksum, ram_din} !== 32'h0) begin n_fail++; $display("FAIL reset_data: checksum %h din %h want 0", checksum, ram_din); end
    n_run++; if (ram_ad !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", ram_ad); end
    rst = 1'b0;
    @(posedge clk); #1;
    wl_cyc.delete(); wl_ad.delete(); wl_d.delete();
    s_valid = 1'b1; s_data = 16'h5555;
    #1;
    n_run++; if ({s_ready, ram_wre} !== 2'b00) begin n_fail++; $display("FAIL idle_ignore: ready/wre %b want 00", {s_ready, ram_wre}); end
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    n_run++; if (wl_ad.size() != 0) begin n_fail++; $display("FAIL idle_writes: got %0d want 0", wl_ad.size()); end
    obs = {boot_mode, cpu_rst_n, s_ready, ram_ce, ram_wre, done, error};
    n_run++; if (obs !== 7'b1000000) begin n_fail++; $display("FAIL idle_status: got %b want 1000000", obs); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    for (int i = 0; i < 17; i++) img[i] = 16'h00A1 + DATA_W'(i);
    run_load(17, 0, 1'b0, 1'b0, r);
    n_run++; if (r.timed_out) begin n_fail++; $display("FAIL b2b_timeout: got timeout want done"); end
    n_run++; if (r.nwr != 17) begin n_fail++; $display("FAIL b2b_nwr: got %0d want 17", r.nwr); end
    n_run++; if (!(r.addr_ok && r.data_ok)) begin n_fail++; $display("FAIL b2b_log: addr_ok %0b data_ok %0b want 1 1", r.addr_ok, r.data_ok); end
    n_run++; if (!r.consec) begin n_fail++; $display("FAIL b2b_consec: got 0 want 1"); end
    n_run++; if (r.vcycles != 17 + RD_LAT + 1) begin n_fail++; $display("FAIL b2b_verify_len: got %0d want %0d", r.vcycles, 17 + RD_LAT + 1); end
    n_run++; if ({done, error, cpu_rst_n, boot_mode} !== 4'b1010) begin n_fail++; $display("FAIL b2b_status: got %b want 1010", {done, error, cpu_rst_n, boot_mode}); end
    n_run++; if (checksum !== model_sum(17)) begin n_fail++; $display("FAIL b2b_checksum: got %h want %h", checksum, model_sum(17)); end
    n_run++; if (ram_bad_words(17) != 0) begin n_fail++; $display("FAIL b2b_ram: got %0d bad words want 0", ram_bad_words(17)); end
  endtask

  task automatic test_gapped();
    res_t r;
    run_load(17, 1, 1'b0, 1'b1, r);
    n_run++; if (r.timed_out || r.nwr != 17) begin n_fail++; $display("FAIL gap_nwr: got %0d timeout %0b want 17 0", r.nwr, r.timed_out); end
    n_run++; if (!(r.addr_ok && r.data_ok)) begin n_fail++; $display("FAIL gap_log: addr_ok %0b data_ok %0b want 1 1", r.addr_ok, r.data_ok); end
    n_run++; if (wl_cyc.size() == 17 && wl_cyc[16] - wl_cyc[0] != 32) begin n_fail++; $display("FAIL gap_spacing: got %0d want 32", wl_cyc[16] - wl_cyc[0]); end
    n_run++; if ({done, error} !== 2'b10 || checksum !== model_sum(17)) begin n_fail++; $display("FAIL gap_done: done/err %b chk %h want 10 %h", {done, error}, checksum, model_sum(17)); end
  endtask

  task automatic test_corrupt();
    res_t r;
    for (int i = 0; i < 12; i++) img[i] = DATA_W'($urandom);
    run_load(12, 0, 1'b1, 1'b0, r);
    n_run++; if (r.timed_out) begin n_fail++; $display("FAIL corrupt_timeout: got timeout want error"); end
    n_run++; if ({error, done, cpu_rst_n, boot_mode, ram_ce} !== 5'b10010) begin n_fail++; $display("FAIL corrupt_status: got %b want 10010", {error, done, cpu_rst_n, boot_mode, ram_ce}); end
    n_run++; if (checksum !== model_sum(12)) begin n_fail++; $display("FAIL corrupt_checksum: got %h want %h", checksum, model_sum(12)); end
    n_run++; if (r.vcycles != 12 + RD_LAT + 1) begin n_fail++; $display("FAIL corrupt_verify_len: got %0d want %0d", r.vcycles, 12 + RD_LAT + 1); end
  endtask

  task automatic test_zero_len();
    res_t r;
    run_load(0, 0, 1'b0, 1'b0, r);
    n_run++; if (r.vcycles != 0 || done !== 1'b1) begin n_fail++; $display("FAIL zero_done: cycles %0d done %b want 0 1", r.vcycles, done); end
    n_run++; if (r.nwr != 0 || checksum !== '0) begin n_fail++; $display("FAIL zero_writes: nwr %0d chk %h want 0 0", r.nwr, checksum); end
    cpu_addr = 11'h123;
    #1;
    n_run++; if ({ram_ce, ram_wre, ram_ad, ram_din} !== {2'b10, 11'h123, 16'h0}) begin n_fail++; $display("FAIL zero_cpu_mux: ce %b wre %b ad %h din %h want 1 0 123 0", ram_ce, ram_wre, ram_ad, ram_din); end
    cpu_addr = 11'h7FE;
    #1;
    n_run++; if (ram_ad !== 11'h7FE) begin n_fail++; $display("FAIL zero_cpu_mux2: got %h want 7fe", ram_ad); end
  endtask

  task automatic test_reset_mid_load();
    res_t r;
    for (int i = 0; i < 17; i++) img[i] = DATA_W'($urandom);
    wl_cyc.delete(); wl_ad.delete(); wl_d.delete();
    start = 1'b1; prog_len = 17;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = img[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_run++; if (wl_ad.size() != 8) begin n_fail++; $display("FAIL mid_partial: got %0d writes want 8", wl_ad.size()); end
    rst = 1'b1;
    #1;
    n_run++; if ({s_ready, boot_mode, cpu_rst_n, done, error, ram_wre} !== 6'b010000) begin n_fail++; $display("FAIL mid_reset: got %b want 010000", {s_ready, boot_mode, cpu_rst_n, done, error, ram_wre}); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load(17, 0, 1'b0, 1'b0, r);
    n_run++; if (!(r.addr_ok && r.data_ok) || done !== 1'b1) begin n_fail++; $display("FAIL mid_reload: addr_ok %0b data_ok %0b done %b want 1 1 1", r.addr_ok, r.data_ok, done); end
    for (int i = 0; i < 17; i++) img[i] = DATA_W'($urandom);
    run_load(17, 2, 1'b0, 1'b0, r);
    n_run++; if (r.rstn_at_load !== 1'b0) begin n_fail++; $display("FAIL done_restart_rstn: got %b want 0", r.rstn_at_load); end
    n_run++; if (!(r.addr_ok && r.data_ok) || done !== 1'b1 || checksum !== model_sum(17)) begin n_fail++; $display("FAIL done_restart: ok %0b%0b done %b chk %h want 11 1 %h", r.addr_ok, r.data_ok, done, checksum, model_sum(17)); end
  endtask

  task automatic test_random();
    res_t r;
    int len;
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) img[i] = DATA_W'($urandom);
      run_load(len, 2, 1'b0, 1'b0, r);
      n_run++; if (r.timed_out || !(r.addr_ok && r.data_ok)) begin n_fail++; $display("FAIL rand%0d_log: len %0d nwr %0d ok %0b%0b", it, len, r.nwr, r.addr_ok, r.data_ok); end
      n_run++; if (done !== 1'b1 || checksum !== model_sum(len)) begin n_fail++; $display("FAIL rand%0d_sum: done %b chk %h want 1 %h", it, done, checksum, model_sum(len)); end
      n_run++; if (ram_bad_words(len) != 0) begin n_fail++; $display("FAIL rand%0d_ram: got %0d bad words want 0", it, ram_bad_words(len)); end
    end
  endtask

  task automatic test_full_depth();
    res_t r;
    for (int i = 0; i < DEPTH; i++) img[i] = DATA_W'($urandom);
    run_load(3000, 0, 1'b0, 1'b0, r);
    n_run++; if (r.timed_out || r.nwr != DEPTH) begin n_fail++; $display("FAIL full_nwr: got %0d timeout %0b want %0d 0", r.nwr, r.timed_out, DEPTH); end
    n_run++; if (!(r.addr_ok && r.data_ok && r.consec)) begin n_fail++; $display("FAIL full_log: ok %0b%0b%0b want 111", r.addr_ok, r.data_ok, r.consec); end
    n_run++; if (r.vcycles != DEPTH + RD_LAT + 1) begin n_fail++; $display("FAIL full_verify_len: got %0d want %0d", r.vcycles, DEPTH + RD_LAT + 1); end
    n_run++; if (done !== 1'b1 || checksum !== model_sum(DEPTH)) begin n_fail++; $display("FAIL full_sum: done %b chk %h want 1 %h", done, checksum, model_sum(DEPTH)); end
    n_run++; if (ram_bad_words(DEPTH) != 0) begin n_fail++; $display("FAIL full_ram: got %0d bad words want 0", ram_bad_words(DEPTH)); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped();
    test_corrupt();
    test_zero_len();
    test_reset_mid_load();
    test_random();
    test_full_depth();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
